// File: rtl/cell_particle_reader.sv
// Streams one cell's particles from a 2-cycle-latency position memory into a
// 4-entry FWFT FIFO; reads are credit-gated so downstream stalls never drop data.
module cell_particle_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] particle_pos_o,
  output logic [ADDR_WIDTH-1:0] particle_id_o,
  output logic                  particle_valid_o,
  input  logic                  particle_ready_i
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;

  state_t                         state_q;
  logic [ADDR_WIDTH-1:0]          cnt_q, next_addr_q;
  logic [1:0]                     vld_pipe_q;
  logic [1:0][ADDR_WIDTH-1:0]     addr_pipe_q;
  logic [DATA_WIDTH-1:0]          fifo_pos_q [4];
  logic [ADDR_WIDTH-1:0]          fifo_id_q  [4];
  logic [1:0]                     wptr_q, rptr_q;
  logic [2:0]                     fifo_cnt_q, fifo_cnt_d;
  logic [2:0]                     inflight;
  logic                           issue, push, pop;
  logic [ADDR_WIDTH-1:0]          cnt_raw, cnt_clamped;

  // Credit = FIFO entries plus reads still in the memory pipe; never exceeds 4.
  always_comb begin
    inflight    = 3'(vld_pipe_q[0]) + 3'(vld_pipe_q[1]);
    issue       = (state_q == STREAM) && ((fifo_cnt_q + inflight) < 3'd4);
    push        = vld_pipe_q[1] && ((state_q == STREAM) || (state_q == DRAIN));
    pop         = particle_valid_o && particle_ready_i;
    fifo_cnt_d  = fifo_cnt_q + 3'(push) - 3'(pop);
    cnt_raw     = rd_data_i[ADDR_WIDTH-1:0];
    cnt_clamped = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;
  end

  assign rd_en_o          = issue || (state_q == RD_CNT);
  assign rd_addr_o        = issue ? next_addr_q : '0;
  assign busy_o           = state_q inside {RD_CNT, WAIT_CNT, STREAM, DRAIN};
  assign done_o           = (state_q == DONE);
  assign particle_valid_o = (fifo_cnt_q != 3'd0);
  assign particle_pos_o   = particle_valid_o ? fifo_pos_q[rptr_q] : '0;
  assign particle_id_o    = particle_valid_o ? fifo_id_q[rptr_q]  : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pos_q[wptr_q] <= rd_data_i;
      fifo_id_q[wptr_q]  <= addr_pipe_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      next_addr_q <= '0;
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[0], rd_en_o};
      addr_pipe_q <= {addr_pipe_q[0], rd_addr_o};
      fifo_cnt_q  <= fifo_cnt_d;
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
      if (issue) next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
      case (state_q)
        IDLE:     if (start_i) state_q <= RD_CNT;
        RD_CNT:   state_q <= WAIT_CNT;
        WAIT_CNT: if (vld_pipe_q[1]) begin
          cnt_q       <= cnt_clamped;
          next_addr_q <= ADDR_WIDTH'(1);
          state_q     <= (cnt_clamped == '0) ? DONE : STREAM;
        end
        STREAM:   if (issue && (next_addr_q == cnt_q)) state_q <= DRAIN;
        // Leave as the last word is accepted so done lands right after it.
        DRAIN:    if ((vld_pipe_q == 2'b00) && (fifo_cnt_d == 3'd0)) state_q <= DONE;
        DONE:     state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule
